bus_dev_fifo: RTL and testbench

BUS_DEV_FIFO -- requirements
Module: bus_dev_fifo

---
 rtl/bus_pkg.sv | 14 +
 rtl/bus_dev_fifo.sv | 103 ++++++++++
 tb/tb_bus_dev_fifo.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared bus-side constants and helpers used by device FIFOs, the arbiter and benches.
package bus_pkg;

    localparam int unsigned PCKG_SZ_DEFAULT = 16;
    localparam int unsigned DROP_CNT_W      = 8;

    typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

    // Width needed to hold an occupancy value in the range 0..d.
    function automatic int unsigned cnt_w(input int unsigned d);
        return $clog2(d + 1);
    endfunction

endpackage

// File: rtl/bus_dev_fifo.sv
// Per-driver show-ahead packet FIFO feeding one slot of the shared bus.
// Head packet is always visible on D_pop while pndng is high; writes into a
// full queue are dropped and recorded in sticky overflow / saturating drop_cnt.
module bus_dev_fifo
    import bus_pkg::*;
#(
    parameter int unsigned pckg_sz = PCKG_SZ_DEFAULT,
    parameter int unsigned depth   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [pckg_sz-1:0]         wr_data,
    output logic                       full,
    output logic                       pndng,
    output logic [pckg_sz-1:0]         D_pop,
    input  logic                       pop,
    output logic [cnt_w(depth)-1:0]    count,
    output logic                       overflow,
    output logic [DROP_CNT_W-1:0]      drop_cnt
);

    localparam int unsigned CW = cnt_w(depth);
    localparam int unsigned PW = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(depth);
    localparam logic [PW-1:0] LAST_C  = PW'(depth - 1);

    logic [pckg_sz-1:0] mem [depth];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [1:0]         rst_sync;
    logic               rst_int_n;
    logic               is_empty;
    logic               is_full;
    logic               do_pop;
    logic               do_wr;
    logic               do_drop;

    // Reset asserts immediately, release is taken through two flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    // Accept / drop decisions for this cycle.
    always_comb begin
        is_empty = (count == '0);
        is_full  = (count == DEPTH_C);
        do_pop   = pop && !is_empty;
        // A pop while full frees the slot the simultaneous write lands in.
        do_wr    = wr_en && (!is_full || pop);
        do_drop  = wr_en && is_full && !pop;
    end

    // Pointer, occupancy and drop-tracking state.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + PW'(1);
            end
            case ({do_wr, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (do_drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + DROP_CNT_W'(1);
                end
            end
        end
    end

    // Packet storage; contents are not reset, only guarded by count.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Status and show-ahead head packet, forced to zero when empty.
    always_comb begin
        full  = is_full;
        pndng = !is_empty;
        D_pop = pndng ? mem[rd_ptr] : '0;
    end

endmodule

// File: tb/tb_bus_dev_fifo.sv
// Self-checking bench for bus_dev_fifo: queue-based reference model, scoreboard
// of expected popped packets, and a monitor comparing D_pop on each pop.
module tb_bus_dev_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PSZ   = 16;

    logic           clk;
    logic           reset;
    logic           wr_en;
    logic [PSZ-1:0] wr_data;
    logic           full;
    logic           pndng;
    logic [PSZ-1:0] D_pop;
    logic           pop;
    logic [2:0]     count;
    logic           overflow;
    logic [7:0]     drop_cnt;

    bus_dev_fifo #(.pckg_sz(PSZ), .depth(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .count    (count),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    typedef struct {
        bit             valid;
        logic [PSZ-1:0] data;
    } exp_t;

    logic [PSZ-1:0] mq[$];
    exp_t           sb[$];
    bit             m_ovf;
    int             m_drops;
    int             n_checks;
    int             n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: every pop request is matched against the scoreboard entry.
    always @(negedge clk) begin
        if (reset && pop) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pop_pndng", 32'(pndng), 32'(e.valid));
                chk("pop_data", 32'(D_pop), e.valid ? 32'(e.data) : 32'd0);
            end
        end
    end

    task automatic check_state();
        chk("count", 32'(count), 32'(mq.size()));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("pndng", 32'(pndng), 32'(mq.size() != 0));
        chk("D_pop", 32'(D_pop), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
    endtask

    // One clock of stimulus with the reference model advanced alongside.
    task automatic cycle(input bit w, input logic [PSZ-1:0] d, input bit p);
        exp_t e;
        wr_en   = w;
        wr_data = d;
        pop     = p;
        if (p) begin
            e.valid = (mq.size() != 0);
            e.data  = e.valid ? mq[0] : '0;
            sb.push_back(e);
            if (e.valid) void'(mq.pop_front());
        end
        if (w) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(d);
            end else begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
            end
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        pop   = 1'b0;
        check_state();
    endtask

    // Mid-cycle reset pulse; outputs must clear without a clock edge.
    task automatic reset_pulse();
        #3;
        reset = 1'b0;
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_pndng", 32'(pndng), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_D_pop", 32'(D_pop), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        mq.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) cycle(1'b0, '0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_ovf    = 1'b0;
        m_drops  = 0;
        reset    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        pop      = 1'b0;
        @(posedge clk);
        #1;
        check_state();
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) cycle(1'b0, '0, 1'b0);

        // Single write then pop.
        cycle(1'b1, 16'hA001, 1'b0);
        cycle(1'b0, '0, 1'b1);

        // Fill, overflow, drain in order.
        for (int unsigned i = 1; i <= 4; i++) cycle(1'b1, 16'(i), 1'b0);
        cycle(1'b1, 16'h0005, 1'b0);
        repeat (4) cycle(1'b0, '0, 1'b1);

        // Write and pop together while full.
        reset_pulse();
        for (int unsigned i = 1; i <= 4; i++) cycle(1'b1, 16'h0010 + 16'(i), 1'b0);
        cycle(1'b1, 16'h00FF, 1'b1);
        repeat (4) cycle(1'b0, '0, 1'b1);

        // Empty: pop alone ignored, pop with write accepts the write.
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 16'hBEEF, 1'b1);
        cycle(1'b0, '0, 1'b1);

        // Reset with three entries queued.
        for (int unsigned i = 0; i < 3; i++) cycle(1'b1, 16'h7000 + 16'(i), 1'b0);
        reset_pulse();
        cycle(1'b1, 16'h1234, 1'b0);
        cycle(1'b0, '0, 1'b1);

        // Saturating drop counter.
        for (int unsigned i = 0; i < 4; i++) cycle(1'b1, 16'h0100 + 16'(i), 1'b0);
        for (int unsigned i = 0; i < 300; i++) cycle(1'b1, 16'(i), 1'b0);
        repeat (4) cycle(1'b0, '0, 1'b1);

        // Random traffic from a clean state.
        reset_pulse();
        for (int unsigned i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 2) != 0));
        end
        while (mq.size() != 0) cycle(1'b0, '0, 1'b1);

        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
